// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC controller with valid/ready result port
// Binary search over the DAC code, one bit per SETTLE/DECIDE round, result held until accepted.
module sar_adc_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             COMP,
  output logic             SAMPLE,
  output logic [WIDTH-1:0] DAC_D,
  output logic             busy,
  output logic [WIDTH-1:0] DATA,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRACK,
    S_SETTLE,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_idx_dn;
  logic [WIDTH-1:0] r_dac;
  logic [WIDTH-1:0] w_dac_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_sample;
  logic             w_sample_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_overrun;
  logic             w_overrun_nxt;
  logic             r_comp_meta;
  logic             r_comp_s;
  logic             w_accept;

  // COMP is asynchronous to CLK; only the second flop is ever looked at.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_comp_meta <= 1'b0;
      r_comp_s    <= 1'b0;
    end else begin
      r_comp_meta <= COMP;
      r_comp_s    <= r_comp_meta;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_dac     <= '0;
      r_data    <= '0;
      r_sample  <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_dac     <= w_dac_nxt;
      r_data    <= w_data_nxt;
      r_sample  <= w_sample_nxt;
      r_busy    <= w_busy_nxt;
      r_valid   <= w_valid_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign w_accept = r_valid & ready;
  assign w_idx_dn = r_idx - IDX_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_dac_nxt     = r_dac;
    w_data_nxt    = r_data;
    w_sample_nxt  = r_sample;
    w_busy_nxt    = r_busy;
    w_valid_nxt   = r_valid;
    w_overrun_nxt = r_overrun;

    if (w_accept) begin
      w_valid_nxt   = 1'b0;
      w_overrun_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_TRACK;
          w_sample_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
          w_cnt_nxt    = SAMPLE_LOAD;
        end
      end
      S_TRACK: begin
        if (r_cnt == '0) begin
          w_state_nxt  = S_SETTLE;
          w_sample_nxt = 1'b0;
          w_idx_nxt    = IDX_TOP;
          w_dac_nxt    = MSB_CODE;
          w_cnt_nxt    = SETTLE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DECIDE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DECIDE: begin
        // The trial bit is already 1, so keeping or clearing it is just comp_s.
        w_dac_nxt[r_idx] = r_comp_s;
        if (r_idx == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt         = S_SETTLE;
          w_idx_nxt           = w_idx_dn;
          w_dac_nxt[w_idx_dn] = 1'b1;
          w_cnt_nxt           = SETTLE_LOAD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_data_nxt  = r_dac;
        w_valid_nxt = 1'b1;
        if (r_valid && !ready) begin
          w_overrun_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign SAMPLE  = r_sample;
  assign DAC_D   = r_dac;
  assign busy    = r_busy;
  assign DATA    = r_data;
  assign valid   = r_valid;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - directed checks for sar_adc_ctrl against a behavioural comparator
module tb_sar_adc_ctrl;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       COMP = 1'b0;
  logic       ready = 1'b0;
  logic       SAMPLE;
  logic [9:0] DAC_D;
  logic       busy;
  logic [9:0] DATA;
  logic       valid;
  logic       overrun;
  logic [9:0] VIN = 10'h000;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] trials [10];
  int         lat;
  int         scnt;

  sar_adc_ctrl #(.WIDTH(10), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .start   (start),
    .COMP    (COMP),
    .SAMPLE  (SAMPLE),
    .DAC_D   (DAC_D),
    .busy    (busy),
    .DATA    (DATA),
    .valid   (valid),
    .ready   (ready),
    .overrun (overrun)
  );

  always #5 CLK = ~CLK;

  // Analog comparator settles half a cycle after the DAC code moves.
  always @(negedge CLK) COMP <= (VIN >= DAC_D);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic convert(input logic [9:0] vin);
    int idx;
    idx  = 0;
    lat  = -1;
    scnt = 0;
    VIN   = vin;
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    if (SAMPLE) scnt++;
    for (int n = 1; n <= 100; n++) begin
      @(posedge CLK); #1;
      if (n >= 4 && (n - 4) % 3 == 0 && idx < 10) begin
        trials[idx] = DAC_D;
        idx++;
      end
      if (SAMPLE) scnt++;
      if (!busy) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic accept();
    ready = 1'b1;
    @(posedge CLK); #1 ready = 1'b0;
  endtask

  initial begin
    int busy_fall;
    int v1;
    int v2;
    int nsamp;
    logic [9:0] exp_trial;

    #1;
    check("rst_sample", SAMPLE, 0);
    check("rst_dac", DAC_D, 0);
    check("rst_busy", busy, 0);
    check("rst_data", DATA, 0);
    check("rst_valid", valid, 0);
    check("rst_overrun", overrun, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) reset = 1'b1;
    @(posedge CLK); #1;

    convert(10'h2A5);
    check("c1_latency", lat, 35);
    check("c1_valid", valid, 1);
    check("c1_data", DATA, 10'h2A5);
    check("c1_trial0", trials[0], 10'h200);
    check("c1_trial1", trials[1], 10'h300);
    check("c1_trial2", trials[2], 10'h280);
    check("c1_sample_cycles", scnt, 4);
    check("c1_idle_dac_holds", DAC_D, 10'h2A5);
    check("c1_overrun", overrun, 0);
    accept();
    check("c1_valid_cleared", valid, 0);

    convert(10'h3FF);
    check("fs_latency", lat, 35);
    check("fs_data", DATA, 10'h3FF);
    accept();

    convert(10'h000);
    check("zero_latency", lat, 35);
    check("zero_data", DATA, 10'h000);
    exp_trial = 10'h200;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("zero_trial%0d", k), trials[k], exp_trial);
      exp_trial = exp_trial >> 1;
    end
    check("zero_final_dac", DAC_D, 10'h000);
    accept();

    convert(10'h155);
    check("hs1_valid", valid, 1);
    check("hs1_data", DATA, 10'h155);
    check("hs1_overrun", overrun, 0);
    convert(10'h0AA);
    check("hs2_valid", valid, 1);
    check("hs2_data", DATA, 10'h0AA);
    check("hs2_overrun", overrun, 1);
    accept();
    check("hs_acc_valid", valid, 0);
    check("hs_acc_overrun", overrun, 0);

    VIN   = 10'h2A5;
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (11) @(posedge CLK);
    #1;
    check("mid_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_sample", SAMPLE, 0);
    check("mid_rst_dac", DAC_D, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    @(negedge CLK) reset = 1'b1;
    @(posedge CLK); #1;
    convert(10'h1C3);
    check("restart_latency", lat, 35);
    check("restart_data", DATA, 10'h1C3);
    accept();

    VIN       = 10'h0F0;
    busy_fall = -1;
    start     = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK); #1;
      if (n == 4) start = 1'b1;
      if (n == 20) start = 1'b0;
      if (!busy && busy_fall < 0) busy_fall = n;
    end
    check("ign_busy_fall", busy_fall, 35);
    check("ign_busy_after", busy, 0);
    check("ign_data", DATA, 10'h0F0);
    check("ign_overrun", overrun, 0);
    accept();

    VIN   = 10'h2A5;
    ready = 1'b1;
    start = 1'b1;
    v1    = -1;
    v2    = -1;
    nsamp = 0;
    for (int n = 0; n <= 75; n++) begin
      @(posedge CLK); #1;
      if (SAMPLE && n <= 70) nsamp++;
      if (valid) begin
        if (v1 < 0) v1 = n;
        else if (v2 < 0) v2 = n;
      end
    end
    start = 1'b0;
    check("b2b_first_valid", v1, 35);
    check("b2b_spacing", v2 - v1, 36);
    check("b2b_sample_cycles", nsamp, 8);
    check("b2b_data", DATA, 10'h2A5);
    for (int n = 0; n < 60 && busy; n++) begin
      @(posedge CLK); #1;
    end
    check("b2b_drain", busy, 0);
    ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
